pe_operand_collector: RTL and testbench

Operand-gathering stage directly upstream of the PE `ALU` instance. It accepts up to three independently handshaked operand streams from the tile routing and buffers each in a small FIFO. When every operand the configured operation needs is available, it fires one aligned operand triple into a registered output that drives `data_in1`/`data_in2`/`data_in3` of the ALU. Back-pressure comes from the downstream result stage.

---
 rtl/pe_pkg.sv | 31 +++
 rtl/pe_operand_fifo.sv | 68 ++++++
 rtl/pe_operand_collector.sv | 138 +++++++++++++
 tb/tb_pe_operand_collector.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE operand-gathering datapath: widths, depths,
// the per-operand sourcing mode and its decoder.
package pe_pkg;

  localparam int PE_DATA_WIDTH         = 32;
  localparam int PE_NUM_OPERANDS       = 3;
  localparam int PE_OPERAND_FIFO_DEPTH = 2;

  // Where an ALU operand comes from for the configured operation.
  typedef enum logic [1:0] {
    OPM_UNUSED = 2'd0,
    OPM_STREAM = 2'd1,
    OPM_CONST  = 2'd2
  } operand_mode_t;

  // The const-select bit overrides the use bit: a constant operand never
  // consumes from its stream, even if the operation also marks it as used.
  function automatic operand_mode_t decode_operand_mode(input logic use_bit,
                                                        input logic const_bit);
    operand_mode_t mode;
    if (const_bit) begin
      mode = OPM_CONST;
    end else if (use_bit) begin
      mode = OPM_STREAM;
    end else begin
      mode = OPM_UNUSED;
    end
    return mode;
  endfunction

endpackage

// File: rtl/pe_operand_fifo.sv
// Small first-word-fall-through FIFO holding pending beats of one operand
// stream. The head entry is visible on pop_data whenever empty is low.
module pe_operand_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        count_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // A push into a full FIFO is dropped even if a pop frees a slot in the
  // same cycle; the producer only sees ready from the registered count.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is read straight out of the array so the data falls through.
  assign pop_data = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pe_operand_collector.sv
// Gathers up to three operand streams for the PE ALU, buffering each in its
// own FIFO, and fires one aligned operand triple into a registered output
// once every operand the configured operation needs is on hand.
module pe_operand_collector
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int FIFO_DEPTH = PE_OPERAND_FIFO_DEPTH
) (
  input  logic                  UserCLK,
  input  logic                  rst_n,
  input  logic [2:0]            cfg_use,
  input  logic [2:0]            cfg_const_sel,
  input  logic [DATA_WIDTH-1:0] cfg_const,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [DATA_WIDTH-1:0] in2_data,
  input  logic [DATA_WIDTH-1:0] in3_data,
  input  logic                  in1_valid,
  input  logic                  in2_valid,
  input  logic                  in3_valid,
  output logic                  in1_ready,
  output logic                  in2_ready,
  output logic                  in3_ready,
  output logic [DATA_WIDTH-1:0] data_in1,
  output logic [DATA_WIDTH-1:0] data_in2,
  output logic [DATA_WIDTH-1:0] data_in3,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int NOPS = PE_NUM_OPERANDS;

  logic [DATA_WIDTH-1:0] in_data [NOPS];
  logic [NOPS-1:0]       in_valid;
  logic [NOPS-1:0]       in_ready_w;
  logic [NOPS-1:0]       is_stream;
  logic [NOPS-1:0]       fifo_push;
  logic [NOPS-1:0]       fifo_pop;
  logic [NOPS-1:0]       fifo_full;
  logic [NOPS-1:0]       fifo_empty;
  logic [NOPS-1:0]       avail;
  logic                  active_reg;
  logic                  out_valid_reg;
  logic                  fire;

  assign in_data[0] = in1_data;
  assign in_data[1] = in2_data;
  assign in_data[2] = in3_data;
  assign in_valid   = {in3_valid, in2_valid, in1_valid};

  assign in1_ready = in_ready_w[0];
  assign in2_ready = in_ready_w[1];
  assign in3_ready = in_ready_w[2];

  // Marks the first cycle after reset release so that every ready stays low
  // while reset is held and rises only once the FIFOs are known empty.
  always_ff @(posedge UserCLK) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
    end else begin
      active_reg <= 1'b1;
    end
  end

  // A new triple may enter the output register when all operands are present
  // and the register is either empty or being drained this very cycle.
  assign fire = (&avail) && (!out_valid_reg || out_ready);

  generate
    for (genvar gi = 0; gi < NOPS; gi++) begin : g_operand
      operand_mode_t         mode;
      logic [DATA_WIDTH-1:0] head;
      logic [DATA_WIDTH-1:0] operand_next;
      logic [DATA_WIDTH-1:0] data_reg;

      assign mode          = decode_operand_mode(cfg_use[gi], cfg_const_sel[gi]);
      assign is_stream[gi] = (mode == OPM_STREAM);

      // Non-stream operands always accept and discard, so an idle or
      // unrelated route never stalls its sender.
      assign in_ready_w[gi] = active_reg && (!is_stream[gi] || !fifo_full[gi]);
      assign fifo_push[gi]  = is_stream[gi] && in_valid[gi] && in_ready_w[gi];
      assign fifo_pop[gi]   = is_stream[gi] && fire;
      assign avail[gi]      = !is_stream[gi] || !fifo_empty[gi];

      pe_operand_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
      ) u_fifo (
        .clk       (UserCLK),
        .rst_n     (rst_n),
        .push      (fifo_push[gi]),
        .push_data (in_data[gi]),
        .pop       (fifo_pop[gi]),
        .pop_data  (head),
        .full      (fifo_full[gi]),
        .empty     (fifo_empty[gi])
      );

      // Select the value this operand contributes to the next triple.
      always_comb begin
        operand_next = '0;
        unique case (mode)
          OPM_STREAM: operand_next = head;
          OPM_CONST:  operand_next = cfg_const;
          default:    operand_next = '0;
        endcase
      end

      // Operand output register: loads on fire, otherwise holds its value.
      always_ff @(posedge UserCLK) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (fire) begin
          data_reg <= operand_next;
        end
      end
    end
  endgenerate

  // Output valid: set on fire (also when draining in the same cycle, so a
  // back-to-back stream has no bubble), cleared when consumed without refill.
  always_ff @(posedge UserCLK) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
    end else if (fire) begin
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign data_in1  = g_operand[0].data_reg;
  assign data_in2  = g_operand[1].data_reg;
  assign data_in3  = g_operand[2].data_reg;

endmodule

// File: tb/tb_pe_operand_collector.sv
// Directed bench for pe_operand_collector: basic fire, stream skew, constant
// operand, back-pressure and mid-run reset, with hand-derived expectations.
module tb_pe_operand_collector;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } triple_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    cfg_use;
  logic [2:0]    cfg_const_sel;
  logic [DW-1:0] cfg_const;
  logic [DW-1:0] in1_data, in2_data, in3_data;
  logic          in1_valid, in2_valid, in3_valid;
  logic          in1_ready, in2_ready, in3_ready;
  logic [DW-1:0] data_in1, data_in2, data_in3;
  logic          out_valid;
  logic          out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];
  logic [DW-1:0] q3 [$];
  triple_t       exp_q [$];

  always #5 clk = ~clk;

  pe_operand_collector #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (2)
  ) dut (
    .UserCLK       (clk),
    .rst_n         (rst_n),
    .cfg_use       (cfg_use),
    .cfg_const_sel (cfg_const_sel),
    .cfg_const     (cfg_const),
    .in1_data      (in1_data),
    .in2_data      (in2_data),
    .in3_data      (in3_data),
    .in1_valid     (in1_valid),
    .in2_valid     (in2_valid),
    .in3_valid     (in3_valid),
    .in1_ready     (in1_ready),
    .in2_ready     (in2_ready),
    .in3_ready     (in3_ready),
    .data_in1      (data_in1),
    .data_in2      (data_in2),
    .data_in3      (data_in3),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in1_valid = 1'b0; in2_valid = 1'b0; in3_valid = 1'b0;
    in1_data  = '0;   in2_data  = '0;   in3_data  = '0;
  endtask

  task automatic drive3(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    in1_valid = 1'b1; in2_valid = 1'b1; in3_valid = 1'b1;
    in1_data  = a;    in2_data  = b;    in3_data  = c;
  endtask

  task automatic apply_reset(input logic [2:0] use_v, input logic [2:0] csel_v, input logic [DW-1:0] cval);
    rst_n = 1'b0;
    idle_inputs();
    out_ready     = 1'b0;
    cfg_use       = use_v;
    cfg_const_sel = csel_v;
    cfg_const     = cval;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic triple_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    triple_t t;
    t.a = a; t.b = b; t.c = c;
    return t;
  endfunction

  // Cycle-driven stream player: each stream offers queue heads from its start
  // cycle on, out_ready is held low before 'hold'. Every consumed triple is
  // checked against exp_q; held outputs must stay stable.
  task automatic run(input string name, input int s1, input int s2, input int s3,
                     input int hold, input int ncyc, input int rdy_cyc, input bit chk_r3,
                     output int first_c, output int last_c, output int n_cons);
    logic          hs1, hs2, hs3, cons, held;
    logic [DW-1:0] p1, p2, p3;
    triple_t       e;
    first_c = -1; last_c = -1; n_cons = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      in1_valid = (cyc >= s1) && (q1.size() > 0);
      in2_valid = (cyc >= s2) && (q2.size() > 0);
      in3_valid = (cyc >= s3) && (q3.size() > 0);
      in1_data  = in1_valid ? q1[0] : 32'h0BAD_0001;
      in2_data  = in2_valid ? q2[0] : 32'h0BAD_0002;
      in3_data  = in3_valid ? q3[0] : 32'h0BAD_0003;
      out_ready = (cyc >= hold);
      #1;
      if (chk_r3) check({name, "_in3_ready"}, {31'd0, in3_ready}, 32'd1);
      if (cyc == rdy_cyc) check({name, "_in1_ready_low"}, {31'd0, in1_ready}, 32'd0);
      hs1  = in1_valid && in1_ready;
      hs2  = in2_valid && in2_ready;
      hs3  = in3_valid && in3_ready;
      cons = out_valid && out_ready;
      held = out_valid && !out_ready;
      p1 = data_in1; p2 = data_in2; p3 = data_in3;
      step();
      if (hs1) void'(q1.pop_front());
      if (hs2) void'(q2.pop_front());
      if (hs3) void'(q3.pop_front());
      if (cons) begin
        $display("%s: cycle %0d triple (0x%08h, 0x%08h, 0x%08h)", name, cyc, p1, p2, p3);
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        n_cons++;
        if (exp_q.size() == 0) begin
          check({name, "_extra_triple"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({name, "_d1"}, p1, e.a);
          check({name, "_d2"}, p2, e.b);
          check({name, "_d3"}, p3, e.c);
        end
      end
      if (held) begin
        check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_hold_d1"}, data_in1, p1);
        check({name, "_hold_d2"}, data_in2, p2);
        check({name, "_hold_d3"}, data_in3, p3);
      end
    end
    idle_inputs();
    check({name, "_missing_triples"}, exp_q.size(), 32'd0);
    check({name, "_unsent_in1"}, q1.size(), 32'd0);
    check({name, "_unsent_in2"}, q2.size(), 32'd0);
  endtask

  initial begin
    int fc, lc, nc;

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    out_ready     = 1'b0;
    cfg_use       = 3'b011;
    cfg_const_sel = 3'b000;
    cfg_const     = '0;
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data_in1", data_in1, 32'd0);
    check("rst_data_in3", data_in3, 32'd0);
    check("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    check("rst_in3_ready", {31'd0, in3_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in1_ready", {31'd0, in1_ready}, 32'd1);
    check("post_rst_in3_ready", {31'd0, in3_ready}, 32'd1);

    // Basic fire: 2-cycle latency, valid for exactly one cycle
    in1_valid = 1'b1; in1_data = 32'd5;
    in2_valid = 1'b1; in2_data = 32'd7;
    out_ready = 1'b1;
    step();
    idle_inputs();
    check("basic_lat1_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    check("basic_d1", data_in1, 32'd5);
    check("basic_d2", data_in2, 32'd7);
    check("basic_d3", data_in3, 32'd0);
    $display("basic: triple (0x%08h, 0x%08h, 0x%08h)", data_in1, data_in2, data_in3);
    step();
    check("basic_one_cycle", {31'd0, out_valid}, 32'd0);
    check("basic_hold_d1", data_in1, 32'd5);

    // Skew: in2 silent for 4 cycles while in1 fills its FIFO
    apply_reset(3'b011, 3'b000, '0);
    q1 = '{32'd1, 32'd2, 32'd3};
    q2 = '{32'd10, 32'd20, 32'd30};
    q3 = '{};
    exp_q = '{};
    exp_q.push_back(mk(32'd1, 32'd10, 32'd0));
    exp_q.push_back(mk(32'd2, 32'd20, 32'd0));
    exp_q.push_back(mk(32'd3, 32'd30, 32'd0));
    run("skew", 0, 4, 1000, 0, 14, 2, 1'b0, fc, lc, nc);
    check("skew_count", nc, 32'd3);

    // Const operand 3; junk on in3 must always be accepted and ignored
    apply_reset(3'b111, 3'b100, 32'hDEAD_BEEF);
    q1 = '{32'd11, 32'd12, 32'd13, 32'd14};
    q2 = '{32'd21, 32'd22, 32'd23, 32'd24};
    q3 = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    exp_q = '{};
    exp_q.push_back(mk(32'd11, 32'd21, 32'hDEAD_BEEF));
    exp_q.push_back(mk(32'd12, 32'd22, 32'hDEAD_BEEF));
    exp_q.push_back(mk(32'd13, 32'd23, 32'hDEAD_BEEF));
    exp_q.push_back(mk(32'd14, 32'd24, 32'hDEAD_BEEF));
    run("const", 0, 0, 0, 0, 12, -1, 1'b1, fc, lc, nc);
    check("const_count", nc, 32'd4);
    check("const_in3_drained", q3.size(), 32'd0);

    // Back-pressure: out_ready low for 6 cycles, then 3 triples back-to-back
    apply_reset(3'b111, 3'b000, '0);
    q1 = '{32'd101, 32'd102, 32'd103};
    q2 = '{32'd201, 32'd202, 32'd203};
    q3 = '{32'd301, 32'd302, 32'd303};
    exp_q = '{};
    exp_q.push_back(mk(32'd101, 32'd201, 32'd301));
    exp_q.push_back(mk(32'd102, 32'd202, 32'd302));
    exp_q.push_back(mk(32'd103, 32'd203, 32'd303));
    run("bp", 0, 0, 0, 6, 14, 5, 1'b0, fc, lc, nc);
    check("bp_count", nc, 32'd3);
    check("bp_first_cycle", fc, 32'd6);
    check("bp_no_bubble", lc - fc, 32'd2);

    // Reset mid-run with 2 entries buffered per FIFO and a held output
    apply_reset(3'b111, 3'b000, '0);
    out_ready = 1'b0;
    drive3(32'd1, 32'd2, 32'd3); step();
    drive3(32'd4, 32'd5, 32'd6); step();
    drive3(32'd7, 32'd8, 32'd9); step();
    idle_inputs();
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    check("mid_pre_full", {31'd0, in1_ready}, 32'd0);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_d1", data_in1, 32'd0);
    check("mid_rst_d2", data_in2, 32'd0);
    check("mid_rst_d3", data_in3, 32'd0);
    rst_n = 1'b1;
    step();
    check("mid_release_ready", {31'd0, in2_ready}, 32'd1);
    check("mid_release_valid", {31'd0, out_valid}, 32'd0);
    drive3(32'h55, 32'h66, 32'h77);
    out_ready = 1'b1;
    step();
    idle_inputs();
    check("mid_new_lat1", {31'd0, out_valid}, 32'd0);
    step();
    check("mid_new_valid", {31'd0, out_valid}, 32'd1);
    check("mid_new_d1", data_in1, 32'h55);
    check("mid_new_d2", data_in2, 32'h66);
    check("mid_new_d3", data_in3, 32'h77);
    $display("mid: triple (0x%08h, 0x%08h, 0x%08h)", data_in1, data_in2, data_in3);
    step();
    check("mid_no_stale", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
